// File: rtl/core_halt_ctrl_pkg.sv
// Shared MIPS definitions for the halt controller and the instruction
// classifier: opcode/rt/funct fields, halt-report encodings, FSM states and
// a saturating counter helper.
package core_halt_ctrl_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;

  // REGIMM rt field (inst[20:16])
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  // SPECIAL funct field (inst[5:0])
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  // Halt report encodings
  localparam logic [1:0] DONE_NONE    = 2'b00;
  localparam logic [1:0] DONE_SYSCALL = 2'b01;
  localparam logic [1:0] DONE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } halt_state_e;

  // Increment by one when enabled, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    logic [31:0] res;
    res = val;
    if (en && (val != 32'hFFFF_FFFF)) begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/core_halt_ctrl_inst_class.sv
// Purely combinational instruction classifier: flags control-transfer and
// load/store instructions. Shared with the core-level bench, so it carries
// no state and no clock.
module inst_class
  import core_halt_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_branch,
  output logic        is_mem
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];

  // Every REGIMM encoding is treated as a control transfer, whatever its rt.
  always_comb begin
    is_branch = 1'b0;
    unique case (opcode)
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: is_branch = 1'b1;
      OP_SPECIAL: is_branch = (funct == FN_JR) || (funct == FN_JALR);
      default:    is_branch = 1'b0;
    endcase
  end

  // Loads and stores, including the unaligned left/right forms.
  always_comb begin
    is_mem = 1'b0;
    unique case (opcode)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: is_mem = 1'b1;
      default: is_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_halt_ctrl.sv
// Run/halt controller wrapped around the MIPS core: gates the core clock
// enable, counts committed instructions by class, stops on syscall or on a
// run-length timeout, and hands a halt report to a ready/valid consumer.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | core stopped, last report and counters held, waiting for start
//   RUN   | core enabled, one commit per cycle, watching syscall/timeout
//   HALT  | core stopped, report valid until the consumer accepts it
module core_halt_ctrl
  import core_halt_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [31:0] SYSCALL_WORD   = {OP_SPECIAL, 20'h00000, FN_SYSCALL}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] v0,
  output logic        core_en,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [1:0]  done_code,
  output logic [31:0] result_pc,
  output logic [31:0] result_v0,
  output logic [31:0] inst_count,
  output logic [31:0] branch_count,
  output logic [31:0] mem_count
);

  // Run-length counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  halt_state_e   state_q;
  halt_state_e   state_d;
  logic [TW-1:0] run_cnt_q;

  logic is_branch;
  logic is_mem;
  logic in_idle;
  logic in_run;
  logic is_syscall;
  logic timeout_hit;
  logic run_start;
  logic halt_now;

  inst_class u_inst_class (
    .inst      (inst),
    .is_branch (is_branch),
    .is_mem    (is_mem)
  );

  assign in_idle     = (state_q == ST_IDLE);
  assign in_run      = (state_q == ST_RUN);
  assign is_syscall  = (inst == SYSCALL_WORD);
  assign timeout_hit = (run_cnt_q == TIMEOUT_LAST);
  assign run_start   = in_idle && start;
  assign halt_now    = in_run && (is_syscall || timeout_hit);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)      state_d = ST_RUN;
      ST_RUN:  if (halt_now)   state_d = ST_HALT;
      ST_HALT: if (done_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so no input reaches them
  // combinationally.
  always_comb begin
    core_en    = 1'b0;
    done_valid = 1'b0;
    unique case (state_q)
      ST_RUN:  core_en    = 1'b1;
      ST_HALT: done_valid = 1'b1;
      default: ;
    endcase
  end

  // Run-length counter: cleared at start, advances every RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
    end else if (run_start) begin
      run_cnt_q <= '0;
    end else if (in_run && !timeout_hit) begin
      run_cnt_q <= run_cnt_q + 1'b1;
    end
  end

  // Commit counters: every RUN cycle is one commit, including the halting one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_count   <= '0;
      branch_count <= '0;
      mem_count    <= '0;
    end else if (run_start) begin
      inst_count   <= '0;
      branch_count <= '0;
      mem_count    <= '0;
    end else if (in_run) begin
      inst_count   <= sat_inc(inst_count, 1'b1);
      branch_count <= sat_inc(branch_count, is_branch);
      mem_count    <= sat_inc(mem_count, is_mem);
    end
  end

  // Halt report capture; syscall wins when it lands on the timeout cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_code <= DONE_NONE;
      result_pc <= '0;
      result_v0 <= '0;
    end else if (run_start) begin
      done_code <= DONE_NONE;
      result_pc <= '0;
      result_v0 <= '0;
    end else if (halt_now) begin
      done_code <= is_syscall ? DONE_SYSCALL : DONE_TIMEOUT;
      result_pc <= pc;
      result_v0 <= v0;
    end
  end

endmodule

// File: tb/tb_core_halt_ctrl.sv
// Directed bench for core_halt_ctrl with a short timeout so the timeout
// paths are reachable: a classification table plus hand-written sequences.
module tb_core_halt_ctrl;

  localparam logic [31:0] W_SYSCALL = 32'h0000000C;
  localparam logic [31:0] W_ADDI    = 32'h21080001;
  localparam logic [31:0] W_NOP     = 32'h00000000;
  localparam logic [31:0] W_JR      = 32'h03E00008;
  localparam logic [31:0] W_JALR    = 32'h0100F809;
  localparam logic [31:0] W_ADD     = 32'h01095020;
  localparam logic [31:0] W_LUI     = 32'h3C010040;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] v0;
  logic        core_en;
  logic        done_valid;
  logic        done_ready;
  logic [1:0]  done_code;
  logic [31:0] result_pc;
  logic [31:0] result_v0;
  logic [31:0] inst_count;
  logic [31:0] branch_count;
  logic [31:0] mem_count;

  int n_pass  = 0;
  int n_total = 0;

  core_halt_ctrl #(.TIMEOUT_CYCLES(8), .SYSCALL_WORD(32'h0000000C)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pc           (pc),
    .inst         (inst),
    .v0           (v0),
    .core_en      (core_en),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_code    (done_code),
    .result_pc    (result_pc),
    .result_v0    (result_v0),
    .inst_count   (inst_count),
    .branch_count (branch_count),
    .mem_count    (mem_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] word;
    logic [31:0] exp_branch;
    logic [31:0] exp_mem;
  } class_vec_t;

  class_vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // I-type word with rs=8, rt=9, imm=4
  function automatic logic [31:0] mk_i(input logic [5:0] op);
    return {op, 5'd8, 5'd9, 16'h0004};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic commit(input logic [31:0] w, input logic [31:0] p, input logic [31:0] v);
    inst = w;
    pc   = p;
    v0   = v;
    tick();
  endtask

  task automatic accept();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] hold_pc;
    int k;

    vecs[0]  = '{"bne",   mk_i(6'h05), 32'd1, 32'd0};
    vecs[1]  = '{"blez",  mk_i(6'h06), 32'd1, 32'd0};
    vecs[2]  = '{"bgtz",  mk_i(6'h07), 32'd1, 32'd0};
    vecs[3]  = '{"bltz",  32'h05000003, 32'd1, 32'd0};
    vecs[4]  = '{"bgezal",32'h05110003, 32'd1, 32'd0};
    vecs[5]  = '{"j",     32'h08100004, 32'd1, 32'd0};
    vecs[6]  = '{"jalr",  W_JALR,       32'd1, 32'd0};
    vecs[7]  = '{"lb",    mk_i(6'h20), 32'd0, 32'd1};
    vecs[8]  = '{"lh",    mk_i(6'h21), 32'd0, 32'd1};
    vecs[9]  = '{"lwl",   mk_i(6'h22), 32'd0, 32'd1};
    vecs[10] = '{"lbu",   mk_i(6'h24), 32'd0, 32'd1};
    vecs[11] = '{"lhu",   mk_i(6'h25), 32'd0, 32'd1};
    vecs[12] = '{"lwr",   mk_i(6'h26), 32'd0, 32'd1};
    vecs[13] = '{"sb",    mk_i(6'h28), 32'd0, 32'd1};
    vecs[14] = '{"sh",    mk_i(6'h29), 32'd0, 32'd1};
    vecs[15] = '{"swl",   mk_i(6'h2A), 32'd0, 32'd1};
    vecs[16] = '{"swr",   mk_i(6'h2E), 32'd0, 32'd1};
    vecs[17] = '{"addi",  W_ADDI,      32'd0, 32'd0};
    vecs[18] = '{"add",   W_ADD,       32'd0, 32'd0};
    vecs[19] = '{"lui",   W_LUI,       32'd0, 32'd0};

    rst = 1'b0; start = 1'b0; done_ready = 1'b0;
    pc = 32'h0; inst = W_NOP; v0 = 32'h0;
    tick(); tick();

    chk("rst_core_en",    32'(core_en), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_code",  32'(done_code), 32'd0);
    chk("rst_inst_count", inst_count, 32'd0);

    // Start arrives together with reset release: honoured on the next edge.
    rst = 1'b1;
    do_start();
    chk("first_start_core_en", 32'(core_en), 32'd1);
    commit(W_ADDI, 32'h00400000, 32'd0);
    commit(W_ADDI, 32'h00400004, 32'd0);
    commit(W_ADDI, 32'h00400008, 32'd0);
    commit(W_SYSCALL, 32'h0040000C, 32'd10);
    chk("sys_done_valid", 32'(done_valid), 32'd1);
    chk("sys_core_en",    32'(core_en), 32'd0);
    chk("sys_done_code",  32'(done_code), 32'd1);
    chk("sys_result_pc",  result_pc, 32'h0040000C);
    chk("sys_result_v0",  result_v0, 32'd10);
    chk("sys_inst_count", inst_count, 32'd4);
    chk("sys_branch",     branch_count, 32'd0);
    chk("sys_mem",        mem_count, 32'd0);

    // Back-pressure: report must hold, start during HALT must be ignored.
    pc = 32'h12345678; v0 = 32'hDEAD; inst = W_ADDI;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      chk("bp_done_valid", 32'(done_valid), 32'd1);
      chk("bp_result_pc",  result_pc, 32'h0040000C);
      chk("bp_inst_count", inst_count, 32'd4);
    end
    start = 1'b0;
    accept();
    chk("acc_done_valid", 32'(done_valid), 32'd0);
    chk("acc_core_en",    32'(core_en), 32'd0);
    tick();
    chk("idle_hold_code", 32'(done_code), 32'd1);
    chk("idle_hold_inst", inst_count, 32'd4);
    chk("idle_hold_pc",   result_pc, 32'h0040000C);

    // Mixed program; a start pulse mid-run must not restart the counters.
    do_start();
    commit(mk_i(6'h23), 32'h00400000, 32'd0);
    start = 1'b1;
    commit(mk_i(6'h2B), 32'h00400004, 32'd0);
    start = 1'b0;
    commit(mk_i(6'h04), 32'h00400008, 32'd0);
    commit(32'h0C100010, 32'h0040000C, 32'd0);
    commit(W_JR, 32'h00400010, 32'd0);
    commit(W_SYSCALL, 32'h00400014, 32'd7);
    chk("mix_mem",    mem_count, 32'd2);
    chk("mix_branch", branch_count, 32'd3);
    chk("mix_inst",   inst_count, 32'd6);
    chk("mix_code",   32'(done_code), 32'd1);
    accept();

    // Timeout: nop held; 8 RUN cycles, HALT seen on cycle 9 after start.
    hold_pc = 32'h00400100;
    inst = W_NOP; pc = hold_pc; v0 = 32'd55;
    do_start();
    k = 0;
    while (!done_valid && k < 20) begin
      tick();
      k++;
    end
    chk("to_latency",   32'(k + 1), 32'd9);
    chk("to_code",      32'(done_code), 32'd2);
    chk("to_inst",      inst_count, 32'd8);
    chk("to_result_pc", result_pc, hold_pc);
    chk("to_result_v0", result_v0, 32'd55);
    accept();

    // Syscall on the timeout cycle.
    do_start();
    for (int i = 0; i < 7; i++) commit(W_NOP, 32'h00400200 + 32'(4 * i), 32'd0);
    commit(W_SYSCALL, 32'h0040021C, 32'd3);
    chk("both_code",  32'(done_code), 32'd1);
    chk("both_inst",  inst_count, 32'd8);
    chk("both_pc",    result_pc, 32'h0040021C);
    accept();

    // Classification table: one instruction then syscall per entry.
    foreach (vecs[i]) begin
      do_start();
      commit(vecs[i].word, 32'h00400300, 32'd0);
      commit(W_SYSCALL, 32'h00400304, 32'd0);
      chk({"cls_branch_", vecs[i].name}, branch_count, vecs[i].exp_branch);
      chk({"cls_mem_", vecs[i].name},    mem_count,    vecs[i].exp_mem);
      chk({"cls_inst_", vecs[i].name},   inst_count,   32'd2);
      accept();
    end

    // Async reset mid-RUN.
    do_start();
    for (int i = 0; i < 5; i++) commit(W_NOP, 32'h00400400, 32'd0);
    chk("mid_inst_before", inst_count, 32'd5);
    chk("mid_core_en_before", 32'(core_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_core_en",    32'(core_en), 32'd0);
    chk("mid_rst_done_valid", 32'(done_valid), 32'd0);
    chk("mid_rst_inst",       inst_count, 32'd0);
    chk("mid_rst_branch",     branch_count, 32'd0);
    chk("mid_rst_mem",        mem_count, 32'd0);
    tick();
    rst = 1'b1;
    do_start();
    chk("post_rst_core_en", 32'(core_en), 32'd1);
    commit(W_SYSCALL, 32'h00400500, 32'd9);
    chk("post_rst_code",    32'(done_code), 32'd1);
    chk("post_rst_inst",    inst_count, 32'd1);
    chk("post_rst_v0",      result_v0, 32'd9);

    // Async reset mid-HALT.
    #2;
    rst = 1'b0;
    #1;
    chk("halt_rst_done_valid", 32'(done_valid), 32'd0);
    chk("halt_rst_code",       32'(done_code), 32'd0);
    chk("halt_rst_pc",         result_pc, 32'd0);
    chk("halt_rst_inst",       inst_count, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_halt_ctrl.md
CORE_HALT_CTRL -- requirements
Module: core_halt_ctrl

Interface
REQ-001 The block SHALL provide parameter TIMEOUT_CYCLES, default 50000, maximum RUN cycles before a forced halt.
REQ-002 The block SHALL provide parameter SYSCALL_WORD, default 32'h0000000C, instruction word that ends a run.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock shared with MIPS_Core.
REQ-005 Port rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-006 Port start  input  1  one-cycle pulse that begins a run.
REQ-007 Port pc  input  32  core PC of the instruction committing this cycle.
REQ-008 Port inst  input  32  instruction word committing this cycle.
REQ-009 Port v0  input  32  core register $v0.
REQ-010 Port core_en  output  1  core clock-enable; core commits one instruction per cycle while high.
REQ-011 Port done_valid  output  1  halt report valid.
REQ-012 Port done_ready  input  1  consumer accepts the halt report.
REQ-013 Port done_code  output  2  01 = syscall, 10 = timeout, 00 = none.
REQ-014 Port result_pc / result_v0  output  32 each  PC and $v0 captured at halt.
REQ-015 Port inst_count / branch_count / mem_count  output  32 each  committed instructions: all, control-transfer, load/store.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALT; core_en = 1 exactly in RUN (registered).
REQ-017 IDLE + start SHALL clear all counters, done_code and results, and enter RUN next cycle; start outside IDLE SHALL be ignored.
REQ-018 In RUN each cycle SHALL count as one commit: inst_count +1; branch_count +1 for j, jal, beq, bne, blez, bgtz, REGIMM, jr, jalr; mem_count +1 for lb, lh, lwl, lw, lbu, lhu, lwr, sb, sh, swl, sw, swr.
REQ-019 All counters SHALL saturate at 32'hFFFFFFFF, no wrap.
REQ-020 RUN with inst == SYSCALL_WORD SHALL count the syscall, capture result_pc = pc and result_v0 = v0, set done_code = 01, and enter HALT next cycle.
REQ-021 A RUN cycle counter SHALL force HALT with done_code = 10 and capture pc/v0 on the cycle it equals TIMEOUT_CYCLES-1 with no syscall.
REQ-022 Syscall and timeout in the same cycle SHALL resolve to done_code = 01.
REQ-023 done_valid SHALL be 1 exactly in HALT; done_valid & done_ready SHALL return to IDLE next cycle.
REQ-024 done_code, results and counters SHALL hold from HALT through IDLE until the next accepted start.
REQ-025 Latency: syscall commit at cycle N -> core_en = 0 and done_valid = 1 at N+1.

Reset
REQ-026 rst = 0 SHALL immediately force IDLE, core_en = 0, done_valid = 0, done_code = 00, and all results and counters to 0, including mid-RUN and mid-HALT.
REQ-027 The first start SHALL be honoured on the first rising edge after rst deasserts.

Structure
REQ-028 Opcode, REGIMM rt and funct constants (OP_*, RT_*, FN_*) and the done_code encodings SHALL come from the shared MIPS definitions file, not local literals.
REQ-029 Instruction classification SHALL be one combinational sub-module, inst_class (inputs inst; outputs is_branch, is_mem), reused by the core testbench.

Verification
REQ-030 start, three addi words, then 32'h0000000C at pc 0x0040000C with v0 = 10 -> done_code 01, result_pc 0x0040000C, result_v0 10, inst_count 4, branch_count 0, mem_count 0.
REQ-031 TIMEOUT_CYCLES = 8, inst held at 0x00000000 -> done_valid on cycle 9 after start, done_code 10, inst_count 8.
REQ-032 Sequence lw, sw, beq, jal, jr, syscall -> mem_count 2, branch_count 3, inst_count 6.
REQ-033 Syscall on the timeout cycle -> done_code 01.
REQ-034 done_ready held 0 for 5 cycles -> done_valid and results stable; start during HALT ignored; done_ready = 1 -> IDLE next cycle.
REQ-035 rst = 0 mid-RUN (inst_count 5) -> core_en, done_valid and all counters 0 immediately; next start runs normally.
